hazard_scoreboard: RTL and testbench
====================================

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 SHALL have parameter NREGS, default 16, number of architectural registers (power of 2, >=2).
REQ-002 SHALL have parameter DEPTH, default 3, number of post-decode stages (X=1, M=2, W=3); range 2..7.
REQ-003 SHALL have parameter ZERO_REG, default 1: 1 = register 0 is hardwired and never tracked.
REQ-004 SHALL have derived widths AW = clog2(NREGS) and SW = clog2(DEPTH+1).
REQ-005 SHALL use one clock; reset is asynchronous and active-low.
REQ-006 Ports:
  clk  in  1  clock, rising edge.
  rst_n  in  1  asynchronous active-low reset.
  issue_valid  in  1  decode presents an instruction.
  issue_wr_en  in  1  the instruction writes a register.
  issue_rd  in  AW  destination register.
  issue_rdy_stage  in  SW  first stage (1..DEPTH) whose result is forwardable; ALU=1, load=2.
  src1_en, src2_en  in  1  each source is read.
  src1, src2  in  AW  source registers.
  freeze  in  1  downstream pipeline held; ages do not advance.
  flush_all  in  1  discard all in-flight producers.
  stall  out  1  decode must hold; the instruction is not accepted.
  fwd_sel1, fwd_sel2  out  SW  stage to forward from; 0 = register file.
  busy_vec  out  NREGS  per-register pending flag, for debug.

Function
REQ-007 SHALL keep one entry per register: busy bit, age[SW], rdy[SW].
REQ-008 SHALL compute stall combinationally: stall = issue_valid AND, for any enabled source, busy AND age < rdy.
REQ-009 SHALL set fwd_selN = age of srcN's entry when srcN_en and busy, otherwise 0; the value is valid only when stall = 0.
REQ-010 SHALL accept an issue when issue_valid AND NOT stall AND NOT freeze AND NOT flush_all.
REQ-011 On an accepted issue with issue_wr_en, the entry for issue_rd SHALL load busy=1, age=1, rdy=issue_rdy_stage on the next edge. The newest producer overwrites any older one (WAW: youngest wins).
REQ-012 Each cycle with freeze=0, every busy entry not being reloaded SHALL increment its age by 1.
REQ-013 An entry at age = DEPTH SHALL clear busy on the next unfrozen edge (retire). The register file provides write-before-read bypass.
REQ-014 If an issue and a retire hit the same register on the same edge, the issue SHALL win.
REQ-015 With freeze=1, all entries SHALL hold and no issue is accepted; stall and fwd_sel still reflect current state.
REQ-016 flush_all SHALL clear every busy bit on the next edge and take priority over issue and freeze.
REQ-017 With ZERO_REG=1, register 0 SHALL never become busy, and a source of 0 SHALL give fwd_sel=0 and no stall.
REQ-018 issue_rdy_stage values of 0 or greater than DEPTH SHALL be clamped to 1 and DEPTH respectively.
REQ-019 Latency: stall and fwd_sel are same-cycle combinational; state updates take effect one cycle after issue.

Reset
REQ-020 On rst_n low, all busy, age and rdy bits SHALL clear asynchronously.
REQ-021 During reset, stall=0, fwd_sel1=fwd_sel2=0 and busy_vec=0.
REQ-022 A reset asserted mid-operation SHALL discard all in-flight state, exactly as flush_all does.

Structure
REQ-023 A shared package hz_pkg SHALL hold the stage constants (STG_RF=0, STG_X=1, STG_M=2, STG_W=3), the default DEPTH and NREGS, and the SW width function.
REQ-024 SHALL instantiate sub-module sb_entry NREGS times via generate. Each sb_entry holds busy/age/rdy with load, advance, retire and clear.
REQ-025 SHALL keep lookup and stall logic in the top as one NREGS:1 mux per source.
REQ-026 SHALL be 120-400 lines of RTL in total.

Verification
REQ-027 ALU back-to-back: issue r3 (rdy=1), next cycle issue src1=r3 -> stall=0, fwd_sel1=1.
REQ-028 Load-use: issue load r5 (rdy=2), next cycle src2=r5 -> stall=1 for 1 cycle, then fwd_sel2=2.
REQ-029 Retire: issue r7 then 3 idle cycles -> fwd_sel=3 in cycle 3, busy_vec[7]=0 in cycle 4.
REQ-030 WAW plus freeze: issue r2 (rdy=2), then r2 (rdy=1), hold freeze=1 for 2 cycles -> fwd_sel1=1 (youngest) and ages unchanged during freeze.
REQ-031 flush_all during issue_valid with r4 busy -> busy_vec=0 next cycle and the new issue is not recorded.
REQ-032 Async reset mid-stream plus r0: assert rst_n=0 between edges -> outputs 0 immediately; after reset, issue rd=0 -> busy_vec stays 0.

Source files
------------

// File: rtl/hz_pkg.sv
// Shared constants for the hazard scoreboard: pipeline stage numbering,
// default geometry and the stage-field width helper.
package hz_pkg;

  localparam int STG_RF = 0;
  localparam int STG_X  = 1;
  localparam int STG_M  = 2;
  localparam int STG_W  = 3;

  localparam int DEF_DEPTH = 3;
  localparam int DEF_NREGS = 16;

  // Width of a stage number able to hold 0..depth
  function automatic int sw_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/sb_entry.sv
// One scoreboard slot: tracks whether a register has an in-flight producer,
// how far down the pipeline it is, and from which stage its result is usable.
module sb_entry
  import hz_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int SW    = sw_width(DEF_DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          freeze,
  input  logic          load,
  input  logic [SW-1:0] load_rdy,
  output logic          busy,
  output logic [SW-1:0] age,
  output logic [SW-1:0] rdy
);

  localparam logic [SW-1:0] AGE_ONE = SW'(STG_X);
  localparam logic [SW-1:0] AGE_MAX = SW'(DEPTH);

  logic          busy_r;
  logic [SW-1:0] age_r;
  logic [SW-1:0] rdy_r;

  // Slot state: flush beats freeze, a new load beats retirement of the old producer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_r <= 1'b0;
      age_r  <= {SW{1'b0}};
      rdy_r  <= {SW{1'b0}};
    end else if (flush) begin
      busy_r <= 1'b0;
      age_r  <= {SW{1'b0}};
      rdy_r  <= {SW{1'b0}};
    end else if (freeze) begin
      busy_r <= busy_r;
      age_r  <= age_r;
      rdy_r  <= rdy_r;
    end else if (load) begin
      busy_r <= 1'b1;
      age_r  <= AGE_ONE;
      rdy_r  <= load_rdy;
    end else if (busy_r && (age_r == AGE_MAX)) begin
      busy_r <= 1'b0;
      age_r  <= {SW{1'b0}};
      rdy_r  <= {SW{1'b0}};
    end else if (busy_r) begin
      busy_r <= 1'b1;
      age_r  <= age_r + AGE_ONE;
      rdy_r  <= rdy_r;
    end else begin
      busy_r <= busy_r;
      age_r  <= age_r;
      rdy_r  <= rdy_r;
    end
  end

  assign busy = busy_r;
  assign age  = age_r;
  assign rdy  = rdy_r;

endmodule

// File: rtl/hazard_scoreboard.sv
// Register hazard scoreboard: per-register producer tracking with same-cycle
// stall and forwarding-stage selection for two source operands.
module hazard_scoreboard
  import hz_pkg::*;
#(
  parameter  int NREGS    = DEF_NREGS,
  parameter  int DEPTH    = DEF_DEPTH,
  parameter  int ZERO_REG = 1,
  localparam int AW       = $clog2(NREGS),
  localparam int SW       = sw_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             issue_valid,
  input  logic             issue_wr_en,
  input  logic [AW-1:0]    issue_rd,
  input  logic [SW-1:0]    issue_rdy_stage,
  input  logic             src1_en,
  input  logic             src2_en,
  input  logic [AW-1:0]    src1,
  input  logic [AW-1:0]    src2,
  input  logic             freeze,
  input  logic             flush_all,
  output logic             stall,
  output logic [SW-1:0]    fwd_sel1,
  output logic [SW-1:0]    fwd_sel2,
  output logic [NREGS-1:0] busy_vec
);

  logic [SW-1:0]    age_s [NREGS];
  logic [SW-1:0]    rdy_s [NREGS];
  logic [NREGS-1:0] load_s;
  logic [SW-1:0]    rdy_clamp_s;
  logic             accept_s;
  logic             src1_busy_s;
  logic             src2_busy_s;
  logic [SW-1:0]    age1_s;
  logic [SW-1:0]    age2_s;
  logic             hz1_s;
  logic             hz2_s;

  // Out-of-range ready stages fold onto the nearest legal stage
  always_comb begin
    rdy_clamp_s = issue_rdy_stage;
    if (issue_rdy_stage == SW'(STG_RF)) begin
      rdy_clamp_s = SW'(STG_X);
    end else if (issue_rdy_stage > SW'(DEPTH)) begin
      rdy_clamp_s = SW'(DEPTH);
    end else begin
      rdy_clamp_s = issue_rdy_stage;
    end
  end

  assign accept_s = issue_valid & ~stall & ~freeze & ~flush_all;

  for (genvar gi = 0; gi < NREGS; gi++) begin : g_entry
    if ((ZERO_REG != 0) && (gi == 0)) begin : g_hardwired
      assign load_s[gi] = 1'b0;
    end else begin : g_tracked
      assign load_s[gi] = accept_s & issue_wr_en & (issue_rd == AW'(gi));
    end

    sb_entry #(
      .DEPTH (DEPTH),
      .SW    (SW)
    ) u_entry (
      .clk      (clk),
      .rst_n    (rst_n),
      .flush    (flush_all),
      .freeze   (freeze),
      .load     (load_s[gi]),
      .load_rdy (rdy_clamp_s),
      .busy     (busy_vec[gi]),
      .age      (age_s[gi]),
      .rdy      (rdy_s[gi])
    );
  end

  // Per-source lookup: a hazard exists while the producer has not reached its ready stage
  always_comb begin
    src1_busy_s = src1_en & busy_vec[src1];
    src2_busy_s = src2_en & busy_vec[src2];
    if ((ZERO_REG != 0) && (src1 == {AW{1'b0}})) begin
      src1_busy_s = 1'b0;
    end else begin
      src1_busy_s = src1_en & busy_vec[src1];
    end
    if ((ZERO_REG != 0) && (src2 == {AW{1'b0}})) begin
      src2_busy_s = 1'b0;
    end else begin
      src2_busy_s = src2_en & busy_vec[src2];
    end
    age1_s = src1_busy_s ? age_s[src1] : {SW{1'b0}};
    age2_s = src2_busy_s ? age_s[src2] : {SW{1'b0}};
    hz1_s  = src1_busy_s && (age_s[src1] < rdy_s[src1]);
    hz2_s  = src2_busy_s && (age_s[src2] < rdy_s[src2]);
  end

  assign stall    = issue_valid & (hz1_s | hz2_s);
  assign fwd_sel1 = age1_s;
  assign fwd_sel2 = age2_s;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench: a pipeline-slot model (which instruction sits in which stage)
// predicts stall/forwarding/busy every cycle; directed literals pin the model.
module tb_hazard_scoreboard;

  localparam int NREGS = 16;
  localparam int DEPTH = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        issue_valid = 1'b0;
  logic        issue_wr_en = 1'b0;
  logic [3:0]  issue_rd = 4'd0;
  logic [1:0]  issue_rdy_stage = 2'd0;
  logic        src1_en = 1'b0;
  logic        src2_en = 1'b0;
  logic [3:0]  src1 = 4'd0;
  logic [3:0]  src2 = 4'd0;
  logic        freeze = 1'b0;
  logic        flush_all = 1'b0;
  logic        stall;
  logic [1:0]  fwd_sel1;
  logic [1:0]  fwd_sel2;
  logic [15:0] busy_vec;

  int pass_cnt = 0;
  int total_cnt = 0;

  // Directed literal expectations, consumed by the compare process
  logic        lit_en = 1'b0;
  logic        lit_stall = 1'b0;
  logic [1:0]  lit_f1 = 2'd0;
  logic [1:0]  lit_f2 = 2'd0;
  logic [15:0] lit_busy = 16'd0;

  // Model: slot k holds the instruction currently in post-decode stage k
  bit m_v   [DEPTH+1];
  int m_rd  [DEPTH+1];
  int m_rdy [DEPTH+1];

  hazard_scoreboard #(.NREGS(NREGS), .DEPTH(DEPTH), .ZERO_REG(1)) dut (
    .clk(clk), .rst_n(rst_n), .issue_valid(issue_valid), .issue_wr_en(issue_wr_en),
    .issue_rd(issue_rd), .issue_rdy_stage(issue_rdy_stage), .src1_en(src1_en),
    .src2_en(src2_en), .src1(src1), .src2(src2), .freeze(freeze), .flush_all(flush_all),
    .stall(stall), .fwd_sel1(fwd_sel1), .fwd_sel2(fwd_sel2), .busy_vec(busy_vec)
  );

  always #5 clk = ~clk;

  // Youngest in-flight producer of reg r: its stage (0 if none)
  function automatic int m_age(input int r);
    for (int k = 1; k <= DEPTH; k++) if (m_v[k] && m_rd[k] == r) return k;
    return 0;
  endfunction

  function automatic int m_rdy_of(input int r);
    for (int k = 1; k <= DEPTH; k++) if (m_v[k] && m_rd[k] == r) return m_rdy[k];
    return 0;
  endfunction

  function automatic bit m_stall();
    int a1, a2;
    a1 = src1_en ? m_age(int'(src1)) : 0;
    a2 = src2_en ? m_age(int'(src2)) : 0;
    return issue_valid && ((a1 != 0 && a1 < m_rdy_of(int'(src1))) ||
                           (a2 != 0 && a2 < m_rdy_of(int'(src2))));
  endfunction

  function automatic logic [15:0] m_busy();
    logic [15:0] b;
    b = 16'd0;
    for (int k = 1; k <= DEPTH; k++) if (m_v[k]) b[m_rd[k]] = 1'b1;
    return b;
  endfunction

  // Model advance: instructions move one stage per unfrozen edge
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k <= DEPTH; k++) m_v[k] <= 1'b0;
    end else if (flush_all) begin
      for (int k = 0; k <= DEPTH; k++) m_v[k] <= 1'b0;
    end else if (!freeze) begin
      for (int k = DEPTH; k >= 2; k--) begin
        m_v[k]   <= m_v[k-1];
        m_rd[k]  <= m_rd[k-1];
        m_rdy[k] <= m_rdy[k-1];
      end
      m_v[1]   <= issue_valid && !m_stall() && issue_wr_en && (issue_rd != 4'd0);
      m_rd[1]  <= int'(issue_rd);
      m_rdy[1] <= (issue_rdy_stage == 2'd0) ? 1 :
                  ((int'(issue_rdy_stage) > DEPTH) ? DEPTH : int'(issue_rdy_stage));
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Compare process: DUT against model every cycle, plus any pending literal
  always @(negedge clk) begin
    logic [1:0] ef1, ef2;
    ef1 = src1_en ? 2'(m_age(int'(src1))) : 2'd0;
    ef2 = src2_en ? 2'(m_age(int'(src2))) : 2'd0;
    chk("stall", 32'(stall), 32'(m_stall()));
    chk("fwd_sel1", 32'(fwd_sel1), 32'(ef1));
    chk("fwd_sel2", 32'(fwd_sel2), 32'(ef2));
    chk("busy_vec", 32'(busy_vec), 32'(m_busy()));
    if (lit_en) begin
      chk("lit_stall", 32'(stall), 32'(lit_stall));
      chk("lit_fwd_sel1", 32'(fwd_sel1), 32'(lit_f1));
      chk("lit_fwd_sel2", 32'(fwd_sel2), 32'(lit_f2));
      chk("lit_busy_vec", 32'(busy_vec), 32'(lit_busy));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    issue_valid = 1'b0; issue_wr_en = 1'b0; src1_en = 1'b0; src2_en = 1'b0;
    freeze = 1'b0; flush_all = 1'b0;
  endtask

  task automatic iss(input int rd, input int rdy);
    idle();
    issue_valid = 1'b1; issue_wr_en = 1'b1;
    issue_rd = 4'(rd); issue_rdy_stage = 2'(rdy);
  endtask

  task automatic expect_lit(input logic s, input logic [1:0] f1, input logic [1:0] f2,
                            input logic [15:0] b);
    lit_stall = s; lit_f1 = f1; lit_f2 = f2; lit_busy = b; lit_en = 1'b1;
    @(negedge clk);
    #1 lit_en = 1'b0;
  endtask

  initial begin
    idle();
    repeat (2) @(posedge clk);
    #1;
    expect_lit(1'b0, 2'd0, 2'd0, 16'h0000);
    cyc();
    rst_n = 1'b1;

    // ALU back-to-back
    iss(3, 1); expect_lit(1'b0, 2'd0, 2'd0, 16'h0000); cyc();
    idle(); issue_valid = 1'b1; src1_en = 1'b1; src1 = 4'd3;
    expect_lit(1'b0, 2'd1, 2'd0, 16'h0008); cyc();
    idle(); repeat (4) cyc();

    // Load-use: one stall cycle then forward from M
    iss(5, 2); cyc();
    idle(); issue_valid = 1'b1; src2_en = 1'b1; src2 = 4'd5;
    expect_lit(1'b1, 2'd0, 2'd1, 16'h0020); cyc();
    expect_lit(1'b0, 2'd0, 2'd2, 16'h0020); cyc();
    idle(); repeat (4) cyc();

    // Retire after DEPTH stages
    iss(7, 1); cyc();
    idle(); src1_en = 1'b1; src1 = 4'd7;
    expect_lit(1'b0, 2'd1, 2'd0, 16'h0080); cyc();
    expect_lit(1'b0, 2'd2, 2'd0, 16'h0080); cyc();
    expect_lit(1'b0, 2'd3, 2'd0, 16'h0080); cyc();
    expect_lit(1'b0, 2'd0, 2'd0, 16'h0000); cyc();
    idle(); repeat (2) cyc();

    // WAW youngest wins, freeze holds ages and blocks issue of r9
    iss(2, 2); cyc();
    iss(2, 1); cyc();
    iss(9, 1); freeze = 1'b1; src1_en = 1'b1; src1 = 4'd2;
    expect_lit(1'b0, 2'd1, 2'd0, 16'h0004); cyc();
    expect_lit(1'b0, 2'd1, 2'd0, 16'h0004); cyc();
    idle(); src1_en = 1'b1; src1 = 4'd2;
    expect_lit(1'b0, 2'd1, 2'd0, 16'h0004); cyc();
    expect_lit(1'b0, 2'd2, 2'd0, 16'h0004); cyc();
    idle(); repeat (4) cyc();

    // Flush beats a concurrent issue
    iss(4, 3); cyc();
    iss(6, 1); flush_all = 1'b1;
    expect_lit(1'b0, 2'd0, 2'd0, 16'h0010); cyc();
    idle(); expect_lit(1'b0, 2'd0, 2'd0, 16'h0000); cyc();

    // Ready stage 0 clamps to X
    iss(10, 0); cyc();
    idle(); issue_valid = 1'b1; src1_en = 1'b1; src1 = 4'd10;
    expect_lit(1'b0, 2'd1, 2'd0, 16'h0400); cyc();
    idle(); repeat (4) cyc();

    // Async reset between edges, then r0 is never tracked
    iss(8, 1); cyc();
    idle(); issue_valid = 1'b1; src1_en = 1'b1; src1 = 4'd8;
    #2 rst_n = 1'b0;
    expect_lit(1'b0, 2'd0, 2'd0, 16'h0000);
    cyc();
    rst_n = 1'b1;
    iss(0, 3); cyc();
    idle(); issue_valid = 1'b1; src1_en = 1'b1; src1 = 4'd0; src2_en = 1'b1; src2 = 4'd0;
    expect_lit(1'b0, 2'd0, 2'd0, 16'h0000); cyc();
    idle(); cyc();

    // Random traffic on a small register window to provoke hazards
    for (int i = 0; i < 1500; i++) begin
      issue_valid     = ($urandom_range(0, 3) != 0);
      issue_wr_en     = ($urandom_range(0, 3) != 0);
      issue_rd        = 4'($urandom_range(0, 7));
      issue_rdy_stage = 2'($urandom_range(0, 3));
      src1_en         = ($urandom_range(0, 2) != 0);
      src2_en         = ($urandom_range(0, 2) != 0);
      src1            = 4'($urandom_range(0, 7));
      src2            = 4'($urandom_range(0, 7));
      freeze          = ($urandom_range(0, 7) == 0);
      flush_all       = ($urandom_range(0, 31) == 0);
      if (i == 700) begin
        #2 rst_n = 1'b0;
        @(negedge clk);
        #1 rst_n = 1'b1;
      end
      cyc();
    end

    idle();
    cyc();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
